// File: rtl/loop_nest_ctrl_pkg.sv
// loop_nest_ctrl_pkg: shared defaults and FSM state encoding for the loop-nest sequencer
package loop_nest_ctrl_pkg;
  localparam int LOOP_LEVELS_DEF = 3;
  localparam int LOOP_CNT_W = 12;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/loop_nest_ctrl_level_cnt.sv
// loop_nest_ctrl_level_cnt: one loop level; counts 0..bound-1 and wraps to 0 on increment at last
module loop_nest_ctrl_level_cnt #(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] bound_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             first_o,
  output logic             last_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_o   = cnt_q;
  assign first_o = cnt_q == '0;
  assign last_o  = cnt_q == bound_i - CNT_W'(1);
  // clear wins over increment; an incrementing level at last wraps to 0
  always_comb cnt_d = clr_i ? '0 : (en_i ? (last_o ? '0 : cnt_q + CNT_W'(1)) : cnt_q);
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl: nested-loop sequencer with latched per-layer bounds and a valid/ready step handshake
module loop_nest_ctrl
  import loop_nest_ctrl_pkg::*;
#(
  parameter int LEVELS = LOOP_LEVELS_DEF,
  parameter int CNT_W  = LOOP_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_start,
  input  logic [LEVELS*CNT_W-1:0] cfg_bound,
  input  logic                    abort,
  input  logic                    step_vld,
  output logic                    step_rdy,
  output logic [LEVELS*CNT_W-1:0] cnt_o,
  output logic [LEVELS-1:0]       first_o,
  output logic [LEVELS-1:0]       last_o,
  output logic [LEVELS-1:0]       wrap_o,
  output logic                    busy,
  output logic                    done
);
  state_e                  state_q;
  logic [LEVELS*CNT_W-1:0] bound_q;
  logic                    rdy_q, busy_q, done_q;
  logic [LEVELS-1:0]       en, last;
  logic                    step, start, clr, final_beat;
  assign step_rdy   = rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step       = step_vld & rdy_q & ~abort;
  assign start      = cfg_start & (state_q == IDLE) & ~abort;
  assign clr        = abort | start;
  assign final_beat = en[LEVELS-1] & last[LEVELS-1];
  assign last_o     = last;
  assign wrap_o     = en & last;
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic [CNT_W-1:0] raw, eff;
    assign raw = bound_q[k*CNT_W +: CNT_W];
    assign eff = raw == '0 ? CNT_W'(1) : raw;
    if (k == 0) begin : g_en0
      assign en[k] = step;
    end else begin : g_enk
      assign en[k] = step & (&last[k-1:0]);
    end
    loop_nest_ctrl_level_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en[k]),
      .clr_i   (clr),
      .bound_i (eff),
      .cnt_o   (cnt_o[k*CNT_W +: CNT_W]),
      .first_o (first_o[k]),
      .last_o  (last[k])
    );
  end
  // sequencer FSM: abort beats everything, bounds latched only on an accepted start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bound_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_start) begin
          state_q <= RUN;
          bound_q <= cfg_bound;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b1;
        end
        RUN: if (final_beat) begin
          state_q <= DONE;
          rdy_q   <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_loop_nest_ctrl.sv
// tb_loop_nest_ctrl: directed checks of the loop-nest sequencer against a beat-index model
module tb_loop_nest_ctrl;
  localparam int LW = 3;
  localparam int CW = 12;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_start = 1'b0;
  logic [LW*CW-1:0] cfg_bound = '0;
  logic             abort = 1'b0;
  logic             step_vld = 1'b0;
  logic             step_rdy;
  logic [LW*CW-1:0] cnt_o;
  logic [LW-1:0]    first_o, last_o, wrap_o;
  logic             busy, done;
  int               tests = 0;
  int               fails = 0;

  loop_nest_ctrl #(.LEVELS(LW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_bound (cfg_bound),
    .abort     (abort),
    .step_vld  (step_vld),
    .step_rdy  (step_rdy),
    .cnt_o     (cnt_o),
    .first_o   (first_o),
    .last_o    (last_o),
    .wrap_o    (wrap_o),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rdy"}, 64'(step_rdy), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_wrap"}, 64'(wrap_o), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt_o), 64'd0);
    chk({tag, "_first"}, 64'(first_o), 64'd7);
    chk({tag, "_last"}, 64'(last_o), 64'd7);
  endtask

  task automatic start(input logic [LW*CW-1:0] b);
    cfg_bound = b;
    cfg_start = 1'b1;
    chk("idle_rdy", 64'(step_rdy), 64'd0);
    tick();
    cfg_start = 1'b0;
  endtask

  // e0..e2 are effective bounds; cut_kind 1 = abort, 2 = async reset at beat index cut_at
  task automatic run_seq(input int e0, input int e1, input int e2, input bit tog,
                         input int poke_at, input int cut_at, input int cut_kind);
    int n = 0;
    int cyc = 0;
    int total = e0 * e1 * e2;
    int c0, c1, c2;
    logic [CW-1:0] x0, x1, x2;
    bit v, w0, w1, w2;
    while (n < total && cyc < 400) begin
      c0 = n % e0;
      c1 = (n / e0) % e1;
      c2 = n / (e0 * e1);
      x0 = CW'(c0);
      x1 = CW'(c1);
      x2 = CW'(c2);
      chk("cnt", 64'(cnt_o), 64'({x2, x1, x0}));
      chk("first", 64'(first_o), 64'({c2 == 0, c1 == 0, c0 == 0}));
      chk("last", 64'(last_o), 64'({c2 == e2 - 1, c1 == e1 - 1, c0 == e0 - 1}));
      chk("run_rdy", 64'(step_rdy), 64'd1);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_done", 64'(done), 64'd0);
      if (n == cut_at && cut_kind == 1) begin
        abort = 1'b1;
        step_vld = 1'b1;
        #1;
        chk("abort_wrap", 64'(wrap_o), 64'd0);
        tick();
        abort = 1'b0;
        step_vld = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_cnt", 64'(cnt_o), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_rdy", 64'(step_rdy), 64'd0);
        tick();
        chk("abort_done2", 64'(done), 64'd0);
        return;
      end
      if (n == cut_at && cut_kind == 2) begin
        step_vld = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #2;
        rst_n = 1'b1;
        tick();
        chk("arst_rdy1", 64'(step_rdy), 64'd0);
        chk("arst_busy1", 64'(busy), 64'd0);
        tick();
        chk("arst_rdy2", 64'(step_rdy), 64'd0);
        chk("arst_cnt2", 64'(cnt_o), 64'd0);
        step_vld = 1'b0;
        return;
      end
      v = tog ? (cyc % 2 == 0) : 1'b1;
      step_vld = v;
      if (n == poke_at && v) begin
        cfg_start = 1'b1;
        cfg_bound = {12'd7, 12'd7, 12'd7};
      end
      #1;
      w0 = v && c0 == e0 - 1;
      w1 = w0 && c1 == e1 - 1;
      w2 = w1 && c2 == e2 - 1;
      chk("wrap", 64'(wrap_o), 64'({w2, w1, w0}));
      tick();
      cfg_start = 1'b0;
      if (v) n++;
      cyc++;
    end
    step_vld = 1'b0;
    chk("beat_budget", 64'(n), 64'(total));
    chk("fin_done", 64'(done), 64'd1);
    chk("fin_busy", 64'(busy), 64'd1);
    chk("fin_rdy", 64'(step_rdy), 64'd0);
    chk("fin_cnt", 64'(cnt_o), 64'd0);
    tick();
    chk("post_done", 64'(done), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_rdy", 64'(step_rdy), 64'd0);
  endtask

  initial begin
    #3;
    chk_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_no_start_rdy", 64'(step_rdy), 64'd0);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b0, -1, -1, 0);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b1, -1, -1, 0);
    start({12'd5, 12'd0, 12'd1});
    run_seq(1, 1, 5, 1'b0, -1, -1, 0);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b0, -1, 9, 1);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b0, -1, -1, 0);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b0, 5, -1, 0);
    start({12'd4, 12'd3, 12'd2});
    run_seq(2, 3, 4, 1'b0, -1, 7, 2);
    start({12'd5, 12'd0, 12'd1});
    run_seq(1, 1, 5, 1'b0, -1, -1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
